// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on request, then one round per clock producing the
// sixteen 48-bit subkeys in encryption or reversed (decryption) order.
module des_key_schedule #(
  parameter int KEY_WIDTH        = 64,
  parameter int GEN_KEY_48_WIDTH = 48
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [KEY_WIDTH-1:0]              key,
  input  logic                              start,
  input  logic                              decrypt,
  output logic [15:0][GEN_KEY_48_WIDTH-1:0] subkeys,
  output logic                              keys_valid,
  output logic                              busy
);

  // Tables hold DES bit numbers (1 = MSB of the source vector).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, GEN} state_t;

  state_t                              state_reg, state_next;
  logic [27:0]                         c_reg, c_next, d_reg, d_next;
  logic [4:0]                          round_reg, round_next;
  logic                                dec_reg, dec_next;
  logic                                busy_reg, busy_next;
  logic                                valid_reg, valid_next;
  logic [15:0][GEN_KEY_48_WIDTH-1:0]   subkeys_reg;
  logic                                wr_en;
  logic [3:0]                          wr_idx;
  logic                                single_shift;
  logic [55:0]                         pc1_out;
  logic [55:0]                         cd_rot;
  logic [GEN_KEY_48_WIDTH-1:0]         pc2_out;
  logic [7:0]                          unused_parity;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_out[55-gi] = key[KEY_WIDTH-PC1_TAB[gi]];
    end
    for (gi = 0; gi < GEN_KEY_48_WIDTH; gi++) begin : g_pc2
      assign pc2_out[GEN_KEY_48_WIDTH-1-gi] = cd_rot[56-PC2_TAB[gi]];
    end
    // Parity bits are dropped by PC-1 and intentionally left unconnected.
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign unused_parity[gi] = key[gi*8];
    end
  endgenerate

  assign single_shift = (round_reg == 5'd1) || (round_reg == 5'd2) ||
                        (round_reg == 5'd9) || (round_reg == 5'd16);
  assign cd_rot = single_shift ?
                  {c_reg[26:0], c_reg[27], d_reg[26:0], d_reg[27]} :
                  {c_reg[25:0], c_reg[27:26], d_reg[25:0], d_reg[27:26]};
  assign wr_idx = dec_reg ? 4'(5'd16 - round_reg) : 4'(round_reg - 5'd1);

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    round_next = round_reg;
    dec_next   = dec_reg;
    busy_next  = busy_reg;
    valid_next = valid_reg;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = GEN;
          c_next     = pc1_out[55:28];
          d_next     = pc1_out[27:0];
          dec_next   = decrypt;
          round_next = 5'd1;
          busy_next  = 1'b1;
          valid_next = 1'b0;
        end
      end
      GEN: begin
        c_next     = cd_rot[55:28];
        d_next     = cd_rot[27:0];
        wr_en      = 1'b1;
        round_next = round_reg + 5'd1;
        if (round_reg == 5'd16) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      c_reg       <= '0;
      d_reg       <= '0;
      round_reg   <= '0;
      dec_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      subkeys_reg <= '0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      round_reg <= round_next;
      dec_reg   <= dec_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      if (wr_en)
        subkeys_reg[wr_idx] <= pc2_out;
    end
  end

  assign subkeys    = subkeys_reg;
  assign keys_valid = valid_reg;
  assign busy       = busy_reg;

endmodule
